// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC pop-count / accumulation datapath.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

    // Pop-count width for an N-tap line: counts 0..N inclusive.
    function automatic int unsigned pc_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/pop_count_accum_if.sv
// Sample stream in, run statistics out, for the pop-count accumulator.
interface pop_count_accum_if #(
    parameter int unsigned N            = 64,
    parameter int unsigned LOG2_SAMPLES = 4
);
    import tdc_pkg::*;

    localparam int unsigned W = pc_w(N);
    localparam int unsigned L = LOG2_SAMPLES;

    logic           en;
    logic           start;
    logic           val_in;
    logic [W-1:0]   x;
    logic [W+L-1:0] sum;
    logic [W-1:0]   avg;
    logic [W-1:0]   min_out;
    logic [W-1:0]   max_out;
    logic           val_out;
    logic           busy;

    modport master (
        output en, start, val_in, x,
        input  sum, avg, min_out, max_out, val_out, busy
    );

    modport slave (
        input  en, start, val_in, x,
        output sum, avg, min_out, max_out, val_out, busy
    );

endinterface

// File: rtl/pop_count_min_max.sv
// Registered running min/max tracker; clear preloads min=all ones, max=0.
module pop_count_min_max #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         sample,
    input  logic [W-1:0] x,
    output logic [W-1:0] min_val,
    output logic [W-1:0] max_val
);

    always_ff @(posedge clk) begin
        if (rst) begin
            min_val <= '1;
            max_val <= '0;
        end else if (clear) begin
            min_val <= '1;
            max_val <= '0;
        end else if (sample) begin
            if (x < min_val) min_val <= x;
            if (x > max_val) max_val <= x;
        end
    end

endmodule

// File: rtl/pop_count_accum.sv
// Accumulates 2**LOG2_SAMPLES pop-count samples per run; reports sum, mean, min, max.
module pop_count_accum
    import tdc_pkg::*;
#(
    parameter int unsigned N            = 64,
    parameter int unsigned LOG2_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pop_count_accum_if.slave bus
);

    localparam int unsigned W     = pc_w(N);
    localparam int unsigned L     = LOG2_SAMPLES;
    localparam int unsigned ACC_W = W + L;
    localparam int unsigned CNT_W = (L > 0) ? L : 1;
    localparam int unsigned S     = 1 << L;

    accum_state_t     state;
    accum_state_t     state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     min_val;
    logic [W-1:0]     max_val;
    logic             last_c;
    logic             accept_c;
    logic             clear_c;

    assign last_c   = (count == CNT_W'(S - 1));
    assign accept_c = bus.en && (state == ACCUM) && bus.val_in;
    assign clear_c  = bus.en && (state == IDLE);
    assign bus.busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ACCUM;
            ACCUM:   if (bus.val_in && last_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, sample counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            count       <= '0;
            bus.sum     <= '0;
            bus.avg     <= '0;
            bus.min_out <= '0;
            bus.max_out <= '0;
            bus.val_out <= 1'b0;
        end else if (bus.en) begin
            bus.val_out <= 1'b0;
            case (state)
                IDLE: begin
                    acc   <= '0;
                    count <= '0;
                end
                ACCUM: begin
                    if (bus.val_in) begin
                        acc   <= acc + ACC_W'(bus.x);
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    bus.sum     <= acc;
                    bus.avg     <= acc[ACC_W-1:L];
                    bus.min_out <= min_val;
                    bus.max_out <= max_val;
                    bus.val_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    pop_count_min_max #(.W(W)) u_min_max (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_c),
        .sample  (accept_c),
        .x       (bus.x),
        .min_val (min_val),
        .max_val (max_val)
    );

`ifdef ASSERT_ON
    // Samples above the tap count cannot come from a valid pop-count stage
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            assert (bus.x <= W'(N))
                else $error("pop_count_accum: x=%0d exceeds N=%0d", bus.x, N);
        end
    end
`endif

endmodule

// File: tb/tb_pop_count_accum.sv
// Directed bench for pop_count_accum with hand-computed run results.
module tb_pop_count_accum;

    localparam int unsigned N  = 64;
    localparam int unsigned LS = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    pop_count_accum_if #(.N(N), .LOG2_SAMPLES(LS)) bus ();

    pop_count_accum #(.N(N), .LOG2_SAMPLES(LS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bus.val_in = 1'b1;
        bus.x      = 7'(v);
        tick();
        bus.val_in = 1'b0;
        bus.x      = '0;
    endtask

    task automatic begin_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (bus.val_out !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.val_out), 32'd1);
    endtask

    task automatic check_result(input string tag, input int s, input int a, input int mn, input int mx);
        check({tag, "_sum"}, 32'(bus.sum), 32'(s));
        check({tag, "_avg"}, 32'(bus.avg), 32'(a));
        check({tag, "_min"}, 32'(bus.min_out), 32'(mn));
        check({tag, "_max"}, 32'(bus.max_out), 32'(mx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.start  = 1'b0;
        bus.val_in = 1'b0;
        bus.x      = '0;

        // 1. reset and idle
        tick();
        tick();
        check_result("rst", 0, 0, 0, 0);
        check("rst_val_out", 32'(bus.val_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(5 + i);
            check("idle_val_out", 32'(bus.val_out), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // 2. basic run; val_in alongside start is ignored
        bus.val_in = 1'b1;
        bus.x      = 7'd99;
        begin_run();
        bus.val_in = 1'b0;
        check("run_busy", 32'(bus.busy), 32'd1);
        send(10); send(20); send(30); send(40);
        check("lat_val_out_early", 32'(bus.val_out), 32'd0);
        check("lat_busy_done", 32'(bus.busy), 32'd1);
        tick();
        check("lat_val_out", 32'(bus.val_out), 32'd1);
        check("lat_busy_fall", 32'(bus.busy), 32'd0);
        check_result("basic", 100, 25, 10, 40);
        tick();
        check("pulse_clear", 32'(bus.val_out), 32'd0);
        check("hold_sum", 32'(bus.sum), 32'd100);

        // 3. gaps and en=0 mid-run; val_out held while en=0
        begin_run();
        send(10);
        tick();
        bus.en     = 1'b0;
        bus.val_in = 1'b1;
        bus.x      = 7'd5;
        repeat (3) tick();
        bus.en     = 1'b1;
        bus.val_in = 1'b0;
        send(20);
        tick();
        send(30); send(40);
        tick();
        check("gap_val_out", 32'(bus.val_out), 32'd1);
        check_result("gap", 100, 25, 10, 40);
        bus.en = 1'b0;
        tick();
        tick();
        check("en0_hold_val_out", 32'(bus.val_out), 32'd1);
        bus.en = 1'b1;
        tick();
        check("en1_clear_val_out", 32'(bus.val_out), 32'd0);

        // 4. extremes
        begin_run();
        repeat (4) send(64);
        wait_result("max_wait");
        check_result("max", 256, 64, 64, 64);
        tick();
        begin_run();
        repeat (4) send(0);
        wait_result("zero_wait");
        check_result("zero", 0, 0, 0, 0);
        tick();

        // 5. start ignored in ACCUM/DONE; start coincident with val_out accepted
        begin_run();
        send(1);
        begin_run();
        send(2); send(3); send(4);
        bus.start = 1'b1;
        tick();
        check("done_start_val_out", 32'(bus.val_out), 32'd1);
        check("done_start_busy", 32'(bus.busy), 32'd0);
        check_result("ign", 10, 2, 1, 4);
        tick();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_val_out", 32'(bus.val_out), 32'd0);
        send(5); send(6); send(7); send(8);
        wait_result("b2b_wait");
        check_result("b2b", 26, 6, 5, 8);
        tick();

        // 6. reset mid-run
        begin_run();
        send(7); send(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_result("mid_rst", 0, 0, 0, 0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        send(50);
        begin_run();
        send(1); send(2); send(3); send(4);
        wait_result("fresh_wait");
        check_result("fresh", 10, 2, 1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
